// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller driving external tag/data RAMs.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2,
  parameter int DATA_W  = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               CpuReq,
  input  logic [ADDR_W-1:0]  CpuAddr,
  output logic               CpuReady,
  output logic [DATA_W-1:0]  CpuData,
  input  logic               Flush,
  output logic               MemRead,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic               MemReady,
  input  logic [DATA_W-1:0]  MemData,
  output logic [INDEX_W-1:0] RamAddr,
  output logic [TAG_W-1:0]   TagIn,
  input  logic [TAG_W-1:0]   TagOut,
  output logic [DATA_W-1:0]  DataIn,
  input  logic [DATA_W-1:0]  DataOut,
  output logic               RamWrite
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]        HitCount,
  output logic [31:0]        MissCount
`endif
);

  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:2]   req_addr_reg;
  logic [LINES-1:0]    valid_reg;
  logic [LINES-1:0]    fill_sel;
  logic [INDEX_W-1:0]  req_idx;
  logic [INDEX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic                take_flush;
  logic                fill_done;
  logic                unused_bits;

  assign unused_bits = &{1'b0, CpuAddr[1:0]};

  assign req_idx    = req_addr_reg[INDEX_W+1:2];
  assign req_tag    = req_addr_reg[ADDR_W-1:INDEX_W+2];
  assign cpu_idx    = CpuAddr[INDEX_W+1:2];
  assign hit        = valid_reg[req_idx] && (TagOut == req_tag);
  assign take_flush = (state_reg == IDLE) && Flush;
  // Gating with Rst keeps a response arriving in the reset cycle out of the RAMs.
  assign fill_done  = Rst && (state_reg == FILL) && MemReady;

  // The RAMs see the live CPU index while idle so the lookup read starts on acceptance.
  assign RamAddr = (state_reg == IDLE) ? cpu_idx : req_idx;

  always_comb begin
    CpuReady = 1'b0;
    CpuData  = '0;
    RamWrite = 1'b0;
    TagIn    = '0;
    DataIn   = '0;
    if (Rst && (state_reg == LOOKUP) && hit) begin
      CpuReady = 1'b1;
      CpuData  = DataOut;
    end
    if (fill_done) begin
      RamWrite = 1'b1;
      TagIn    = req_tag;
      DataIn   = MemData;
      CpuReady = 1'b1;
      CpuData  = MemData;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg    <= IDLE;
      req_addr_reg <= '0;
      MemRead      <= 1'b0;
      MemAddr      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!Flush && CpuReq) begin
            req_addr_reg <= CpuAddr[ADDR_W-1:2];
            state_reg    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= FILL;
            MemRead   <= 1'b1;
            MemAddr   <= {req_addr_reg, 2'b00};
          end
        end
        FILL: begin
          if (MemReady) begin
            state_reg <= IDLE;
            MemRead   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_fill_sel
      assign fill_sel[gi] = fill_done && (req_idx == INDEX_W'(gi));
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Rst || take_flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | fill_sel;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else if (state_reg == LOOKUP) begin
      if (hit) HitCount <= HitCount + 32'd1;
      else     MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule
